hw2_2_seq: RTL and testbench

HW2_2_SEQ -- requirements
Module: hw2_2_seq

---
 rtl/hw2_2_seq.sv | 174 +++++++++++++++++
 tb/tb_hw2_2_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hw2_2_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hw2_2_seq : program sequencer feeding instruction words and operands to  |
// | the hw2_2 datapath; HW2_2_SEQ_LOOP_EN enables looping runs. Rev 1.0      |
// +--------------------------------------------------------------------------+
module hw2_2_seq #(
    parameter int PDEPTH = 16,
    parameter int ODEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [8:0] prog_data,
    input  logic       op_we,
    input  logic [2:0] op_addr,
    input  logic [7:0] op_data,
    input  logic [4:0] len,
    input  logic       start,
    input  logic       abort,
    output logic [8:0] c,
    output logic [7:0] data_in,
    input  logic [7:0] data_out,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [8:0] c_NOP = 9'h1f8;

    state_t     state_q, state_d;
    logic [4:0] pc_q, pc_d;
    logic [4:0] len_q, len_d;
    logic [2:0] ptr_q, ptr_d;
    logic [8:0] c_q, c_d;
    logic [7:0] din_q, din_d;
    logic [7:0] result_q, result_d;
    logic [1:0] cap_q, cap_d;
    logic       rv_q, rv_d;
    logic       issue;

    logic [8:0] prog_mem [PDEPTH];
    logic [7:0] op_mem   [ODEPTH];

    logic       w_busy;
    logic       w_len_ok;
    logic       w_mid_run;
    logic [4:0] w_idx;
    logic [2:0] w_base;
    logic [8:0] w_word;
    logic       w_uses;

    assign w_busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign w_len_ok  = (len != 5'd0) && (len <= 5'(PDEPTH));
    // Start and loop-wrap both fetch word 0 with the operand pointer rewound.
    assign w_mid_run = (state_q == S_RUN) && (pc_q != len_q);
    assign w_idx     = w_mid_run ? pc_q : 5'd0;
    assign w_base    = w_mid_run ? ptr_q : 3'd0;
    assign w_word    = prog_mem[w_idx[3:0]];
    assign w_uses    = (w_word[4:3] == 2'b11) || (w_word[6:5] == 2'b11);

    always_ff @(posedge clk) begin
        if (prog_we && !w_busy) prog_mem[prog_addr] <= prog_data;
        if (op_we && !w_busy)   op_mem[op_addr]     <= op_data;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        ptr_d    = ptr_q;
        c_d      = c_NOP;
        din_d    = 8'h00;
        cap_d    = {cap_q[0], 1'b0};
        result_d = result_q;
        rv_d     = 1'b0;
        issue    = 1'b0;

        // Capture two edges after a dst=11 word was issued.
        if (cap_q[1]) begin
            result_d = data_out;
            rv_d     = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start && w_len_ok) begin
                    state_d = S_RUN;
                    len_d   = len;
                    issue   = 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (pc_q != len_q) begin
                    issue = 1'b1;
                end else begin
`ifdef HW2_2_SEQ_LOOP_EN
                    if (start) begin
                        issue = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                        pc_d    = 5'd0;
                    end
`else
                    state_d = S_DRAIN;
                    pc_d    = 5'd0;
`endif
                end
            end
            S_DRAIN: state_d = abort ? S_IDLE : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && w_busy) begin
            cap_d    = 2'b00;
            result_d = result_q;
            rv_d     = 1'b0;
            pc_d     = 5'd0;
            ptr_d    = 3'd0;
        end

        if (issue) begin
            c_d      = w_word;
            din_d    = op_mem[w_base];
            ptr_d    = w_base + {2'b00, w_uses};
            pc_d     = w_idx + 5'd1;
            cap_d[0] = (w_word[8:7] == 2'b11);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= 5'd0;
            len_q    <= 5'd0;
            ptr_q    <= 3'd0;
            c_q      <= c_NOP;
            din_q    <= 8'h00;
            cap_q    <= 2'b00;
            result_q <= 8'h00;
            rv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            ptr_q    <= ptr_d;
            c_q      <= c_d;
            din_q    <= din_d;
            cap_q    <= cap_d;
            result_q <= result_d;
            rv_q     <= rv_d;
        end
    end

    assign c            = c_q;
    assign data_in      = din_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign busy         = w_busy;
    assign done         = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_hw2_2_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hw2_2_seq : scoreboard bench for hw2_2_seq with a queue-based model;  |
// | honours HW2_2_SEQ_LOOP_EN. Rev 1.0                                       |
// +--------------------------------------------------------------------------+
module tb_hw2_2_seq;

    localparam logic [8:0] c_NOP = 9'h1f8;
`ifdef HW2_2_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       prog_we   = 1'b0;
    logic [3:0] prog_addr = 4'd0;
    logic [8:0] prog_data = 9'd0;
    logic       op_we     = 1'b0;
    logic [2:0] op_addr   = 3'd0;
    logic [7:0] op_data   = 8'd0;
    logic [4:0] len       = 5'd0;
    logic       start     = 1'b0;
    logic       abort     = 1'b0;
    logic [7:0] data_out  = 8'd0;
    logic [8:0] c;
    logic [7:0] data_in;
    logic [7:0] result;
    logic       result_valid;
    logic       busy;
    logic       done;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int unsigned seed;

    logic [8:0]  prog_m [16];
    logic [7:0]  op_m   [8];
    logic [16:0] exp_w  [$];
    logic [7:0]  exp_r  [$];
    logic [16:0] ew;

    hw2_2_seq dut (
        .clk          (clk),
        .reset        (reset),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .op_we        (op_we),
        .op_addr      (op_addr),
        .op_data      (op_data),
        .len          (len),
        .start        (start),
        .abort        (abort),
        .c            (c),
        .data_in      (data_in),
        .data_out     (data_out),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: data_out sampled at edge n carries dv(n-1).
    function automatic logic [7:0] dv(input int n);
        logic [31:0] h;
        h = 32'(n) * 32'h9E3779B1 + seed;
        return h[31:24];
    endfunction

    always @(negedge clk) data_out = dv(cyc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_c"},       32'(c),            32'(c_NOP));
        chk({tag, "_data_in"}, 32'(data_in),      32'h0);
        chk({tag, "_result"},  32'(result),       32'h0);
        chk({tag, "_rv"},      32'(result_valid), 32'h0);
        chk({tag, "_busy"},    32'(busy),         32'h0);
        chk({tag, "_done"},    32'(done),         32'h0);
    endtask

    // Monitor: pops one expected word per busy cycle and one result per pulse.
    always @(negedge clk) begin
        if (reset) begin
            if (busy) begin
                if (exp_w.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_extra: got %0h expected none", {c, data_in});
                end else begin
                    ew = exp_w.pop_front();
                    chk("word", 32'({c, data_in}), 32'(ew));
                end
            end else begin
                chk("idle_nop", 32'({c, data_in}), 32'({c_NOP, 8'h00}));
            end
            if (result_valid) begin
                if (exp_r.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL result_extra: got %0h expected none", result);
                end else begin
                    chk("result", 32'(result), 32'(exp_r.pop_front()));
                end
            end
        end
    end

    task automatic wr_prog(input int a, input logic [8:0] w);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'(a); prog_data = w;
        @(negedge clk);
        prog_we = 1'b0;
        prog_m[a] = w;
    endtask

    task automatic wr_op(input int a, input logic [7:0] v);
        @(negedge clk);
        op_we = 1'b1; op_addr = 3'(a); op_data = v;
        @(negedge clk);
        op_we = 1'b0;
        op_m[a] = v;
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 16; i++) wr_prog(i, 9'($urandom));
        for (int i = 0; i < 8; i++)  wr_op(i, 8'($urandom));
    endtask

    // stop_k != 0: cut the run after stop_k busy cycles by abort (abrt) or reset.
    task automatic run(input int ln, input int passes, input int stop_k,
                       input bit abrt, input bit wr_busy);
        int s, np, n, tot, t;
        np  = LOOP ? passes : 1;
        tot = ln * np;
        t   = 0;
        @(negedge clk);
        s = cyc + 1;
        for (int p = 0; p < np; p++) begin
            int ptr;
            ptr = 0;
            for (int i = 0; i < ln; i++) begin
                logic [8:0] w;
                w = prog_m[i];
                if (stop_k == 0 || t < stop_k) exp_w.push_back({w, op_m[ptr]});
                if (w[8:7] == 2'b11 && (stop_k == 0 || t + 3 <= stop_k))
                    exp_r.push_back(dv(s + t + 1));
                if (w[4:3] == 2'b11 || w[6:5] == 2'b11) ptr = (ptr + 1) % 8;
                t++;
            end
        end
        if (stop_k == 0) exp_w.push_back({c_NOP, 8'h00});
        len   = 5'(ln);
        start = 1'b1;
        n = (stop_k != 0) ? stop_k : (LOOP ? tot : ln + 1);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (wr_busy && j == 1) begin
                prog_we = 1'b1; prog_addr = 4'd0; prog_data = c_NOP;
                op_we   = 1'b1; op_addr   = 3'd0; op_data   = ~op_m[0];
            end else begin
                prog_we = 1'b0; op_we = 1'b0;
            end
        end
        prog_we = 1'b0;
        op_we   = 1'b0;
        start   = 1'b0;
        if (stop_k != 0) begin
            if (abrt) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_c", 32'(c), 32'(c_NOP));
                chk("abort_busy", 32'(busy), 32'h0);
                chk("abort_rv", 32'(result_valid), 32'h0);
                chk("abort_done", 32'(done), 32'h0);
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_no_done", 32'(done), 32'h0);
                end
            end else begin
                #1 reset = 1'b0;
                #1 chk_reset_vals("midrun_reset");
                @(negedge clk);
                #1 reset = 1'b1;
                repeat (2) @(negedge clk);
            end
        end else begin
            repeat ((tot + 2) - n) @(negedge clk);
            chk("done_pulse", 32'(done), 32'h1);
            chk("done_busy", 32'(busy), 32'h0);
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'h0);
        end
        #1;
        chk("words_pending", 32'(exp_w.size()), 32'h0);
        chk("results_pending", 32'(exp_r.size()), 32'h0);
    endtask

    task automatic len_bad(input int ln);
        @(negedge clk);
        len   = 5'(ln);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            chk("badlen_busy", 32'(busy), 32'h0);
            chk("badlen_c", 32'(c), 32'(c_NOP));
            chk("badlen_done", 32'(done), 32'h0);
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] demo [11];
        demo = '{9'h018, 9'h098, 9'h121, 9'h042, 9'h093, 9'h124,
                 9'h035, 9'h180, 9'h188, 9'h190, 9'h1f8};
        seed = $urandom;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b1;

        // Reference program from the datapath demo.
        for (int i = 0; i < 16; i++) wr_prog(i, (i < 11) ? demo[i] : 9'($urandom));
        wr_op(0, 8'h03);
        wr_op(1, 8'h05);
        for (int i = 2; i < 8; i++) wr_op(i, 8'($urandom));
        run(10, 1, 0, 1'b0, 1'b0);

        len_bad(0);
        len_bad($urandom_range(17, 31));

        // Writes while busy must be ignored; rerun shows the old contents.
        run(10, 1, 0, 1'b0, 1'b1);
        run(10, 1, 0, 1'b0, 1'b0);

        run(10, 1, 4, 1'b1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rand_mem();
            run($urandom_range(1, 16), $urandom_range(1, 3), 0, 1'b0, 1'b0);
        end

        rand_mem();
        run(16, 1, 0, 1'b0, 1'b0);
        run(1, 2, 0, 1'b0, 1'b0);
        run(12, 1, 5, 1'b0, 1'b0);
        run(12, 1, 0, 1'b0, 1'b0);
        run(8, 1, 7, 1'b1, 1'b0);

`ifdef HW2_2_SEQ_LOOP_EN
        wr_prog(0, 9'h018);
        wr_prog(1, 9'h180);
        wr_op(0, 8'h07);
        wr_op(1, 8'h09);
        run(2, 4, 0, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("final_idle_busy", 32'(busy), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
